vending_machine_param: RTL and testbench



---
 rtl/vending_machine_param_pkg.sv | 21 ++
 rtl/vending_machine_param_change_dispenser.sv | 28 ++
 rtl/vending_machine_param.sv | 179 +++++++++++++++++
 tb/tb_vending_machine_param.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vending_machine_param_pkg.sv
// Shared types and default configuration for the parametrised vending controller.
// Coin values are packed ascending (index 0 = smallest); item prices are packed with item 0 in the LSBs.
package vending_machine_param_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_RETURN = 2'd2
    } vmState_e;

    localparam int kTotalBits     = 16;
    localparam int kNItems        = 4;
    localparam int kNCoins        = 3;
    localparam int kStockBits     = 4;
    localparam int kInitStock     = 10;
    localparam int kTimeoutCycles = 10;

    localparam logic [kNCoins*kTotalBits-1:0] kCoinValues = {16'd1000, 16'd500, 16'd100};
    localparam logic [kNItems*kTotalBits-1:0] kItemPrices = {16'd2000, 16'd1000, 16'd500, 16'd400};

endpackage

// File: rtl/vending_machine_param_change_dispenser.sv
// Greedy change picker: selects the largest coin whose value does not exceed the remaining credit.
// Purely combinational; outputs all-zero when no coin fits.
module change_dispenser
    import vending_machine_param_pkg::*;
#(
    parameter int                              N_COINS     = kNCoins,
    parameter int                              TOTAL_BITS  = kTotalBits,
    parameter logic [N_COINS*TOTAL_BITS-1:0]   COIN_VALUES = kCoinValues
) (
    input  logic [TOTAL_BITS-1:0] total_i,
    output logic [N_COINS-1:0]    coin_o,
    output logic [TOTAL_BITS-1:0] value_o
);

    // Coins are ascending, so the last fitting coin in the scan is the largest one.
    always_comb begin
        coin_o  = '0;
        value_o = '0;
        for (int j = 0; j < N_COINS; j++) begin
            if (COIN_VALUES[j*TOTAL_BITS +: TOTAL_BITS] <= total_i) begin
                coin_o    = '0;
                coin_o[j] = 1'b1;
                value_o   = COIN_VALUES[j*TOTAL_BITS +: TOTAL_BITS];
            end
        end
    end

endmodule

// File: rtl/vending_machine_param.sv
// Parametrised vending controller: coin crediting, item dispense with stock tracking,
// inactivity timeout and one-coin-per-cycle greedy change return.
module vending_machine_param
    import vending_machine_param_pkg::*;
#(
    parameter int                              N_ITEMS        = kNItems,
    parameter int                              N_COINS        = kNCoins,
    parameter int                              TOTAL_BITS     = kTotalBits,
    parameter logic [N_COINS*TOTAL_BITS-1:0]   COIN_VALUES    = kCoinValues,
    parameter logic [N_ITEMS*TOTAL_BITS-1:0]   ITEM_PRICES    = kItemPrices,
    parameter int                              STOCK_BITS     = kStockBits,
    parameter int                              INIT_STOCK     = kInitStock,
    parameter int                              TIMEOUT_CYCLES = kTimeoutCycles
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_COINS-1:0]    i_input_coin,
    input  logic [N_ITEMS-1:0]    i_select_item,
    input  logic                  i_trigger_return,
    input  logic [N_ITEMS-1:0]    i_restock_item,
    output logic [N_ITEMS-1:0]    o_available_item,
    output logic [N_ITEMS-1:0]    o_sold_out,
    output logic [N_ITEMS-1:0]    o_output_item,
    output logic [N_COINS-1:0]    o_return_coin,
    output logic                  o_busy,
    output logic [TOTAL_BITS-1:0] o_current_total
);

    // Extra headroom so a full cycle of coins on top of the credit cannot wrap before the overflow check.
    localparam int SUM_BITS = TOTAL_BITS + $clog2(N_COINS) + 1;
    localparam int SW_BITS  = $clog2(TIMEOUT_CYCLES + 1);

    vmState_e              state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [SW_BITS-1:0]    stopwatch_q, stopwatch_d;
    logic [STOCK_BITS-1:0] stock_q [N_ITEMS];
    logic [STOCK_BITS-1:0] stock_d [N_ITEMS];
    logic [N_ITEMS-1:0]    outputItem_q, outputItem_d;

    logic [SUM_BITS-1:0]   coinSum;
    logic                  coinCredited;
    logic [TOTAL_BITS-1:0] coinAdd;
    logic [N_ITEMS-1:0]    available;
    logic [N_ITEMS-1:0]    soldOut;
    logic [N_ITEMS-1:0]    serveOneHot;
    logic [TOTAL_BITS-1:0] servePrice;
    logic                  serveValid;
    logic [N_COINS-1:0]    changeCoin;
    logic [TOTAL_BITS-1:0] changeValue;

    change_dispenser #(
        .N_COINS    (N_COINS),
        .TOTAL_BITS (TOTAL_BITS),
        .COIN_VALUES(COIN_VALUES)
    ) uChange (
        .total_i(total_q),
        .coin_o (changeCoin),
        .value_o(changeValue)
    );

    // A cycle's coins are credited all-or-nothing; any overflow drops the whole batch.
    always_comb begin
        coinSum = '0;
        for (int j = 0; j < N_COINS; j++) begin
            if (i_input_coin[j]) begin
                coinSum = coinSum + SUM_BITS'(COIN_VALUES[j*TOTAL_BITS +: TOTAL_BITS]);
            end
        end
        coinCredited = (state_q != S_RETURN) && (coinSum != '0) &&
                       ((SUM_BITS'(total_q) + coinSum) <= SUM_BITS'({TOTAL_BITS{1'b1}}));
        coinAdd      = coinCredited ? coinSum[TOTAL_BITS-1:0] : '0;
    end

    // Availability uses the registered (pre-coin) credit; the lowest-index eligible select wins.
    always_comb begin
        available   = '0;
        soldOut     = '0;
        serveOneHot = '0;
        servePrice  = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            soldOut[i]   = (stock_q[i] == '0);
            available[i] = (total_q >= ITEM_PRICES[i*TOTAL_BITS +: TOTAL_BITS]) && (stock_q[i] != '0);
        end
        for (int i = N_ITEMS - 1; i >= 0; i--) begin
            if (i_select_item[i] && available[i]) begin
                serveOneHot    = '0;
                serveOneHot[i] = 1'b1;
                servePrice     = ITEM_PRICES[i*TOTAL_BITS +: TOTAL_BITS];
            end
        end
        serveValid = (state_q == S_CREDIT) && (serveOneHot != '0);
    end

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        stopwatch_d  = stopwatch_q;
        outputItem_d = '0;
        stock_d      = stock_q;

        case (state_q)
            S_IDLE: begin
                if (coinCredited) begin
                    total_d     = total_q + coinAdd;
                    stopwatch_d = SW_BITS'(TIMEOUT_CYCLES);
                    state_d     = S_CREDIT;
                end
            end
            S_CREDIT: begin
                total_d = total_q + coinAdd - (serveValid ? servePrice : '0);
                if (serveValid) begin
                    outputItem_d = serveOneHot;
                    for (int i = 0; i < N_ITEMS; i++) begin
                        if (serveOneHot[i]) begin
                            stock_d[i] = stock_q[i] - STOCK_BITS'(1);
                        end
                    end
                end
                if (coinCredited || serveValid) begin
                    stopwatch_d = SW_BITS'(TIMEOUT_CYCLES);
                end else if (stopwatch_q != '0) begin
                    stopwatch_d = stopwatch_q - SW_BITS'(1);
                end
                // An exact purchase leaves nothing to return, so it goes straight back to idle.
                if (total_d == '0) begin
                    state_d     = S_IDLE;
                    stopwatch_d = '0;
                end else if (i_trigger_return || (!coinCredited && !serveValid && stopwatch_q == '0)) begin
                    state_d     = S_RETURN;
                    stopwatch_d = '0;
                end
            end
            S_RETURN: begin
                // A remainder smaller than every coin cannot be paid out; drop it rather than stall.
                total_d = (changeValue == '0) ? '0 : total_q - changeValue;
                if (total_d == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                total_d     = '0;
                stopwatch_d = '0;
            end
        endcase

        for (int i = 0; i < N_ITEMS; i++) begin
            if (i_restock_item[i]) begin
                stock_d[i] = STOCK_BITS'(INIT_STOCK);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            total_q      <= '0;
            stopwatch_q  <= '0;
            outputItem_q <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= STOCK_BITS'(INIT_STOCK);
            end
        end else begin
            state_q      <= state_d;
            total_q      <= total_d;
            stopwatch_q  <= stopwatch_d;
            outputItem_q <= outputItem_d;
            stock_q      <= stock_d;
        end
    end

    assign o_available_item = available;
    assign o_sold_out       = soldOut;
    assign o_output_item    = outputItem_q;
    assign o_return_coin    = (state_q == S_RETURN) ? changeCoin : '0;
    assign o_busy           = (state_q == S_RETURN);
    assign o_current_total  = total_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed bench for vending_machine_param: a default-configured instance plus a low-stock
// instance (INIT_STOCK=2) for sold-out and restock behaviour.
module tb_vending_machine_param;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [2:0]  coin1, coin2;
    logic [3:0]  sel1, sel2, restock1, restock2;
    logic        ret1, ret2;
    logic [3:0]  avail1, avail2, sold1, sold2, out1, out2;
    logic [2:0]  retc1, retc2;
    logic        busy1, busy2;
    logic [15:0] total1, total2;

    int compared   = 0;
    int mismatched = 0;

    vending_machine_param dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_input_coin(coin1), .i_select_item(sel1), .i_trigger_return(ret1), .i_restock_item(restock1),
        .o_available_item(avail1), .o_sold_out(sold1), .o_output_item(out1),
        .o_return_coin(retc1), .o_busy(busy1), .o_current_total(total1)
    );

    vending_machine_param #(.INIT_STOCK(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .i_input_coin(coin2), .i_select_item(sel2), .i_trigger_return(ret2), .i_restock_item(restock2),
        .o_available_item(avail2), .o_sold_out(sold2), .o_output_item(out2),
        .o_return_coin(retc2), .o_busy(busy2), .o_current_total(total2)
    );

    // Advance one clock and sample just after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        coin1 = '0; sel1 = '0; ret1 = 1'b0; restock1 = '0;
        coin2 = '0; sel2 = '0; ret2 = 1'b0; restock2 = '0;
        #12;
        compared++; if (total1 !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_total: got %0d expected 0", total1); end
        compared++; if (avail1 !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_avail: got %b expected 0000", avail1); end
        compared++; if (sold1 !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_sold: got %b expected 0000", sold1); end
        compared++; if ({out1, retc1, busy1} !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_outs: got %b expected 0", {out1, retc1, busy1}); end
        compared++; if (sold2 !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_sold2: got %b expected 0000", sold2); end
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_coins();
        coin1 = 3'b001;
        for (int k = 0; k < 5; k++) cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd500) begin mismatched++; $display("[TB] FAIL coins_500: got %0d expected 500", total1); end
        compared++; if (avail1 !== 4'b0011) begin mismatched++; $display("[TB] FAIL avail_500: got %b expected 0011", avail1); end
        coin1 = 3'b010;
        for (int k = 0; k < 2; k++) cyc();
        coin1 = 3'b100;
        for (int k = 0; k < 4; k++) cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd5500) begin mismatched++; $display("[TB] FAIL coins_5500: got %0d expected 5500", total1); end
        compared++; if (avail1 !== 4'b1111) begin mismatched++; $display("[TB] FAIL avail_5500: got %b expected 1111", avail1); end
    endtask

    task automatic test_dispense();
        int          items [6] = '{0, 0, 1, 1, 2, 3};
        logic [15:0] totals [6] = '{16'd5100, 16'd4700, 16'd4200, 16'd3700, 16'd2700, 16'd700};
        for (int k = 0; k < 6; k++) begin
            sel1 = 4'b0001 << items[k];
            cyc();
            sel1 = '0;
            compared++; if (out1 !== (4'b0001 << items[k])) begin mismatched++; $display("[TB] FAIL dispense_pulse[%0d]: got %b expected %b", k, out1, 4'b0001 << items[k]); end
            compared++; if (total1 !== totals[k]) begin mismatched++; $display("[TB] FAIL dispense_total[%0d]: got %0d expected %0d", k, total1, totals[k]); end
            cyc();
            compared++; if (out1 !== 4'b0000) begin mismatched++; $display("[TB] FAIL dispense_single[%0d]: got %b expected 0000", k, out1); end
        end
        compared++; if (avail1 !== 4'b0011) begin mismatched++; $display("[TB] FAIL avail_700: got %b expected 0011", avail1); end
    endtask

    task automatic test_timeout();
        logic [2:0] expCoins [5] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b001};
        int busyAt = 0;
        coin1 = 3'b111;
        cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd2300) begin mismatched++; $display("[TB] FAIL timeout_credit: got %0d expected 2300", total1); end
        for (int n = 1; n <= 30; n++) begin
            cyc();
            if (busy1) begin
                busyAt = n;
                break;
            end
        end
        compared++; if (busyAt != 11) begin mismatched++; $display("[TB] FAIL timeout_cycles: got %0d expected 11", busyAt); end
        for (int k = 0; k < 5; k++) begin
            compared++; if (retc1 !== expCoins[k]) begin mismatched++; $display("[TB] FAIL timeout_coin[%0d]: got %b expected %b", k, retc1, expCoins[k]); end
            cyc();
        end
        compared++; if ({busy1, total1} !== 17'd0) begin mismatched++; $display("[TB] FAIL timeout_idle: got busy=%b total=%0d expected 0/0", busy1, total1); end
    endtask

    task automatic test_trigger_return();
        coin1 = 3'b100;
        for (int k = 0; k < 3; k++) cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd3000) begin mismatched++; $display("[TB] FAIL trig_credit: got %0d expected 3000", total1); end
        ret1 = 1'b1;
        cyc();
        ret1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            compared++; if ({busy1, retc1} !== 4'b1100) begin mismatched++; $display("[TB] FAIL trig_coin[%0d]: got busy=%b coin=%b expected 1/100", k, busy1, retc1); end
            cyc();
        end
        compared++; if ({busy1, retc1, total1} !== 20'd0) begin mismatched++; $display("[TB] FAIL trig_done: got busy=%b coin=%b total=%0d expected all 0", busy1, retc1, total1); end
    endtask

    task automatic test_same_cycle();
        coin1 = 3'b001;
        for (int k = 0; k < 4; k++) cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd400) begin mismatched++; $display("[TB] FAIL same_pre: got %0d expected 400", total1); end
        coin1 = 3'b010;
        sel1  = 4'b0001;
        cyc();
        coin1 = '0;
        sel1  = '0;
        compared++; if (out1 !== 4'b0001) begin mismatched++; $display("[TB] FAIL same_pulse: got %b expected 0001", out1); end
        compared++; if (total1 !== 16'd500) begin mismatched++; $display("[TB] FAIL same_total: got %0d expected 500", total1); end
        ret1 = 1'b1;
        cyc();
        ret1 = 1'b0;
        compared++; if (retc1 !== 3'b010) begin mismatched++; $display("[TB] FAIL ret500_coin: got %b expected 010", retc1); end
        coin1 = 3'b100;
        cyc();
        coin1 = '0;
        compared++; if ({busy1, total1} !== 17'd0) begin mismatched++; $display("[TB] FAIL coin_in_return: got busy=%b total=%0d expected 0/0", busy1, total1); end
    endtask

    task automatic test_sold_out();
        coin2 = 3'b100;
        for (int k = 0; k < 2; k++) cyc();
        coin2 = '0;
        compared++; if (avail2 !== 4'b1111) begin mismatched++; $display("[TB] FAIL so_avail_2000: got %b expected 1111", avail2); end
        for (int k = 0; k < 2; k++) begin
            sel2 = 4'b0010;
            cyc();
            sel2 = '0;
            compared++; if (out2 !== 4'b0010) begin mismatched++; $display("[TB] FAIL so_pulse[%0d]: got %b expected 0010", k, out2); end
            cyc();
        end
        compared++; if (total2 !== 16'd1000) begin mismatched++; $display("[TB] FAIL so_total: got %0d expected 1000", total2); end
        compared++; if (sold2 !== 4'b0010) begin mismatched++; $display("[TB] FAIL so_flag: got %b expected 0010", sold2); end
        compared++; if (avail2 !== 4'b0101) begin mismatched++; $display("[TB] FAIL so_avail: got %b expected 0101", avail2); end
        sel2 = 4'b0010;
        cyc();
        sel2 = '0;
        compared++; if (out2 !== 4'b0000) begin mismatched++; $display("[TB] FAIL so_third: got %b expected 0000", out2); end
        compared++; if (total2 !== 16'd1000) begin mismatched++; $display("[TB] FAIL so_third_total: got %0d expected 1000", total2); end
        restock2 = 4'b0010;
        cyc();
        restock2 = '0;
        compared++; if (sold2 !== 4'b0000) begin mismatched++; $display("[TB] FAIL restock_flag: got %b expected 0000", sold2); end
        compared++; if (avail2 !== 4'b0111) begin mismatched++; $display("[TB] FAIL restock_avail: got %b expected 0111", avail2); end
    endtask

    task automatic test_overflow();
        coin1 = 3'b100;
        for (int k = 0; k < 65; k++) cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd65000) begin mismatched++; $display("[TB] FAIL ovf_fill: got %0d expected 65000", total1); end
        coin1 = 3'b100;
        cyc();
        compared++; if (total1 !== 16'd65000) begin mismatched++; $display("[TB] FAIL ovf_1000: got %0d expected 65000", total1); end
        coin1 = 3'b010;
        cyc();
        compared++; if (total1 !== 16'd65500) begin mismatched++; $display("[TB] FAIL ovf_500: got %0d expected 65500", total1); end
        coin1 = 3'b001;
        cyc();
        coin1 = '0;
        compared++; if (total1 !== 16'd65500) begin mismatched++; $display("[TB] FAIL ovf_100: got %0d expected 65500", total1); end
    endtask

    task automatic test_reset_mid_return();
        ret1 = 1'b1;
        cyc();
        ret1 = 1'b0;
        compared++; if ({busy1, retc1} !== 4'b1100) begin mismatched++; $display("[TB] FAIL mid_ret_start: got busy=%b coin=%b expected 1/100", busy1, retc1); end
        for (int k = 0; k < 3; k++) cyc();
        #2 reset_n = 1'b0;
        #1;
        compared++; if (retc1 !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_ret_coin: got %b expected 000", retc1); end
        compared++; if ({busy1, total1} !== 17'd0) begin mismatched++; $display("[TB] FAIL mid_ret_total: got busy=%b total=%0d expected 0/0", busy1, total1); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        cyc();
        compared++; if (total1 !== 16'd0) begin mismatched++; $display("[TB] FAIL post_reset_total: got %0d expected 0", total1); end
    endtask

    initial begin
        test_reset();
        test_coins();
        test_dispense();
        test_timeout();
        test_trigger_return();
        test_same_cycle();
        test_sold_out();
        test_overflow();
        test_reset_mid_return();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
